pipe_ctrl_reg: RTL and testbench
================================

// Module: pipe_ctrl_reg
// PURPOSE
//  Parametrised pipeline register for control bundles (Branch/Jump/MemtoReg and wider) between CPU stages.
//  Delays a DATA_W-bit bundle plus a valid bit by DEPTH cycles.
//  Supports hazard-unit stall (hold) and flush (bubble insert).
//  Replaces the fixed 3-bit control latch between ID/EX/MEM/WB.
// PARAMETERS
//  DATA_W  3     width of control bundle, >=1
//  DEPTH   1     number of register stages, >=1
//  BUBBLE  '0    DATA_W-bit value loaded into a stage on reset/flush (a NOP control word)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-low (0 = reset)
//  stall      in   1       1 = every stage holds its contents
//  flush      in   1       1 = every stage loads BUBBLE, valid=0
//  in_valid   in   1       bundle at in_data is a real instruction
//  in_data    in   DATA_W  control bundle from previous stage
//  out_valid  out  1       valid bit of last stage
//  out_data   out  DATA_W  control bundle of last stage
//  stall_cnt  out  16      stall cycles counted (PIPE_CTRL_STATS_EN only)
//  flush_cnt  out  16      flush cycles counted (PIPE_CTRL_STATS_EN only)
// BEHAVIOUR
//  - All state updates on posedge clk only; no async paths. rst sampled at the edge like any input.
//  - Reset (rst==0): all stages data=BUBBLE, valid=0 -> out_data=BUBBLE, out_valid=0; counters=0.
//  - Priority per edge: reset > flush > stall > shift.
//  - Shift (stall=0, flush=0): stage[0]<={in_valid,in_data}; stage[i]<=stage[i-1]; latency DEPTH cycles.
//  - Stall (stall=1, flush=0): all stages hold; in_data/in_valid ignored (upstream must also hold).
//  - Flush (flush=1): all stages <= {0,BUBBLE} regardless of stall; in_data discarded that cycle.
//  - Data with in_valid=0 still propagates unmodified (no bubble substitution); valid marks it.
//  - out_data/out_valid are registered outputs directly from stage[DEPTH-1]; no combinational in->out path.
//  - Reset asserted mid-stream: contents lost at that edge, first real output DEPTH cycles after rst releases
//    and in_valid=1 with no stall.
//  - DEPTH==1 degenerates to single enable/clear register; DEPTH greater than number of cycles is legal.
// CONFIGURATION
//  - Macro PIPE_CTRL_STATS_EN defined: stall_cnt +1 on every non-reset edge with stall=1 && flush=0;
//    flush_cnt +1 on every non-reset edge with flush=1. Both saturate at 16'hFFFF (no wrap).
//    Cleared only by reset.
//  - Macro undefined: ports stall_cnt/flush_cnt absent, no counter logic generated.
// STRUCTURE
//  - Package pipe_ctrl_pkg: CTRL_W default (3), bit-index constants CTRL_BRANCH=0, CTRL_JUMP=1,
//    CTRL_MEMTOREG=2, CTRL_NOP = '0, STAT_W = 16.
//  - Sub-module pipe_ctrl_stage: one {valid,data} register with rst/flush/stall priority;
//    pipe_ctrl_reg instantiates DEPTH of them in a generate chain; counters live in the top.
// TESTING
//  1 Reset: rst=0 two cycles, DATA_W=3 -> out_data=3'b000, out_valid=0; counters 0.
//  2 Latency: DEPTH=3, drive in_data=3'b101,in_valid=1 at cycle 0 only -> out 3'b101/valid=1 at cycle 3, valid=0 at cycle 4.
//  3 Stall: DEPTH=2, stream 1,2,3,4; stall=1 for 2 cycles after 2 enters -> out sequence holds, no value lost or duplicated beyond hold.
//  4 Flush+stall same edge: pipeline full of valid 3'b111, stall=1,flush=1 -> next cycle out_data=BUBBLE, out_valid=0, all stages empty.
//  5 Reset mid-stream: DEPTH=4 full, rst=0 one edge -> out_valid=0 next cycle, stays 0 until new valid reaches end.
//  6 STATS_EN: stall 5 cycles, flush 3 (one overlapping a stall) -> stall_cnt=4 if overlap inside the 5, flush_cnt=3;
//    force 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_ctrl_pkg                                                   |
// | Purpose  : Shared constants, types and helpers for the control-bundle      |
// |            pipeline register (pipe_ctrl_reg / pipe_ctrl_stage).            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pipe_ctrl_pkg;

  // Default control-bundle width and bit positions of the classic signals
  localparam int CTRL_W        = 3;
  localparam int CTRL_BRANCH   = 0;
  localparam int CTRL_JUMP     = 1;
  localparam int CTRL_MEMTOREG = 2;

  // NOP control word for the default bundle width
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  // Width of the stall/flush statistics counters
  localparam int STAT_W = 16;

  typedef logic [STAT_W-1:0] stat_t;

  // What a stage does on the coming edge
  typedef enum logic [1:0] {
    OP_SHIFT = 2'd0,
    OP_HOLD  = 2'd1,
    OP_CLEAR = 2'd2
  } stage_op_t;

  // Resolve reset > flush > stall > shift into a single stage operation
  function automatic stage_op_t stage_op(input logic rst_n, input logic flush,
                                         input logic stall);
    stage_op_t op;
    op = OP_SHIFT;
    if (!rst_n || flush) begin
      op = OP_CLEAR;
    end else if (stall) begin
      op = OP_HOLD;
    end
    return op;
  endfunction

  // Increment that sticks at all-ones instead of wrapping
  function automatic stat_t sat_inc(input stat_t v);
    stat_t r;
    r = (v == {STAT_W{1'b1}}) ? v : v + stat_t'(1);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_ctrl_stage                                                 |
// | Purpose  : One {valid,data} register of the control pipeline with         |
// |            reset > flush > stall > shift priority.                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int                DATA_W = CTRL_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  stage_op_t         w_op;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  assign w_op = stage_op(rst, flush, stall);

  // Stage register: clear to a bubble, hold, or take the upstream word
  always_ff @(posedge clk) begin
    case (w_op)
      OP_CLEAR: begin
        r_valid <= 1'b0;
        r_data  <= BUBBLE;
      end
      OP_HOLD: begin
        r_valid <= r_valid;
        r_data  <= r_data;
      end
      default: begin
        r_valid <= in_valid;
        r_data  <= in_data;
      end
    endcase
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_ctrl_reg                                                   |
// | Purpose  : DEPTH-stage pipeline register for a DATA_W-bit control bundle   |
// |            plus valid bit, with hazard stall (hold) and flush (bubble).    |
// | Options  : PIPE_CTRL_STATS_EN adds saturating stall/flush cycle counters.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pipe_ctrl_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int                DATA_W = CTRL_W,
  parameter int                DEPTH  = 1,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
`endif
);

  // Chain taps: index 0 is the upstream input, index DEPTH the last stage
  logic              w_chain_valid [DEPTH+1];
  logic [DATA_W-1:0] w_chain_data  [DEPTH+1];

  assign w_chain_valid[0] = in_valid;
  assign w_chain_data[0]  = in_data;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      pipe_ctrl_stage #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (w_chain_valid[gi]),
        .in_data   (w_chain_data[gi]),
        .out_valid (w_chain_valid[gi+1]),
        .out_data  (w_chain_data[gi+1])
      );
    end
  endgenerate

  // Outputs come straight from the last stage's flops
  assign out_valid = w_chain_valid[DEPTH];
  assign out_data  = w_chain_data[DEPTH];

`ifdef PIPE_CTRL_STATS_EN
  stat_t r_stall_cnt;
  stat_t r_flush_cnt;

  // Count flush edges, and stall edges that were not overridden by a flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush) begin
      r_flush_cnt <= sat_inc(r_flush_cnt);
    end else if (stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // Statistics disabled: no counters and no counter ports
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_ctrl_reg                                                |
// | Purpose  : Self-checking bench for pipe_ctrl_reg: four instances of        |
// |            different depth/width share one stimulus stream and are each   |
// |            compared with a queue-based reference pipeline.                 |
// | Options  : PIPE_CTRL_STATS_EN also checks the statistics counters.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pipe_ctrl_reg;

  localparam int          NDUT = 4;
  localparam int          DEP  [NDUT] = '{1, 2, 3, 4};
  localparam logic [7:0]  BUB  [NDUT] = '{8'h00, 8'h00, 8'h00, 8'hA5};
  localparam logic [7:0]  MSK  [NDUT] = '{8'h07, 8'h07, 8'h07, 8'hFF};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       o1v, o2v, o3v, o4v;
  logic [2:0] o1d, o2d, o3d;
  logic [7:0] o4d;
  logic       dv [NDUT];
  logic [7:0] dd [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] sc [NDUT];
  logic [15:0] fc [NDUT];
  int          m_sc = 0;
  int          m_fc = 0;
`endif

  pipe_ctrl_reg #(.DATA_W(3), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data[2:0]),
    .out_valid(o1v), .out_data(o1d)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cnt(sc[0]), .flush_cnt(fc[0])
`endif
  );

  pipe_ctrl_reg #(.DATA_W(3), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data[2:0]),
    .out_valid(o2v), .out_data(o2d)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cnt(sc[1]), .flush_cnt(fc[1])
`endif
  );

  pipe_ctrl_reg #(.DATA_W(3), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data[2:0]),
    .out_valid(o3v), .out_data(o3d)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cnt(sc[2]), .flush_cnt(fc[2])
`endif
  );

  pipe_ctrl_reg #(.DATA_W(8), .DEPTH(4), .BUBBLE(8'hA5)) u_d4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(o4v), .out_data(o4d)
`ifdef PIPE_CTRL_STATS_EN
    , .stall_cnt(sc[3]), .flush_cnt(fc[3])
`endif
  );

  assign dv[0] = o1v;  assign dd[0] = {5'b0, o1d};
  assign dv[1] = o2v;  assign dd[1] = {5'b0, o2d};
  assign dv[2] = o3v;  assign dd[2] = {5'b0, o3d};
  assign dv[3] = o4v;  assign dd[3] = o4d;

  // Reference: each pipeline is a queue of {valid,data}, newest at the front
  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;

  ent_t mq [NDUT][$];

  function automatic void model_clear(int k);
    mq[k].delete();
    for (int i = 0; i < DEP[k]; i++) mq[k].push_back({1'b0, BUB[k]});
  endfunction

  function automatic int sat16(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < NDUT; k++) begin
      if (!rst || flush) begin
        model_clear(k);
      end else if (!stall) begin
        mq[k].push_front({in_valid, in_data & MSK[k]});
        void'(mq[k].pop_back());
      end
    end
`ifdef PIPE_CTRL_STATS_EN
    if (!rst) begin
      m_sc = 0;
      m_fc = 0;
    end else if (flush) begin
      m_fc = sat16(m_fc + 1);
    end else if (stall) begin
      m_sc = sat16(m_sc + 1);
    end
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    ent_t e;
    for (int k = 0; k < NDUT; k++) begin
      e = mq[k][$];
      chk($sformatf("d%0d.out_valid", DEP[k]), {31'b0, dv[k]}, {31'b0, e.v});
      chk($sformatf("d%0d.out_data", DEP[k]), {24'b0, dd[k]}, {24'b0, e.d});
`ifdef PIPE_CTRL_STATS_EN
      chk($sformatf("d%0d.stall_cnt", DEP[k]), {16'b0, sc[k]}, m_sc);
      chk($sformatf("d%0d.flush_cnt", DEP[k]), {16'b0, fc[k]}, m_fc);
`endif
    end
  endtask

  // One clock edge: model sees the same inputs the DUTs sample, compare 1 ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic v, input logic [7:0] d);
    rst = r; stall = s; flush = f; in_valid = v; in_data = d;
  endtask

  typedef struct {
    logic       r, s, f, v;
    logic [2:0] d;
    logic       e1v;
    logic [2:0] e1d;
    logic       e3v;
    logic [2:0] e3d;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [2:0] s_in  [8];
    logic       s_st  [8];
    logic       s_ev  [8];
    logic [2:0] s_ed  [8];

    for (int k = 0; k < NDUT; k++) model_clear(k);

    // Latency / stall / invalid-data / flush+stall / reset, DEPTH 1 and 3
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 3'd3, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 3'd3, 1'b0, 3'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0, 3'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd3};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 1'b0, 3'd0};

    // Reset held for two edges
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    step();
    step();
    chk("reset.d1_data", {29'b0, o1d}, 32'h0);
    chk("reset.d1_valid", {31'b0, o1v}, 32'h0);
    chk("reset.d4_bubble", {24'b0, o4d}, 32'hA5);
`ifdef PIPE_CTRL_STATS_EN
    chk("reset.stall_cnt", {16'b0, sc[2]}, 32'h0);
    chk("reset.flush_cnt", {16'b0, fc[2]}, 32'h0);
`endif

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, {5'b0, tbl[i].d});
      step();
      chk($sformatf("tbl%0d.d1_valid", i), {31'b0, o1v}, {31'b0, tbl[i].e1v});
      chk($sformatf("tbl%0d.d1_data", i),  {29'b0, o1d}, {29'b0, tbl[i].e1d});
      chk($sformatf("tbl%0d.d3_valid", i), {31'b0, o3v}, {31'b0, tbl[i].e3v});
      chk($sformatf("tbl%0d.d3_data", i),  {29'b0, o3d}, {29'b0, tbl[i].e3d});
    end

    // DEPTH=2 stream 1,2,3,4 with a two-cycle stall after 2 enters
    s_in = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0, 3'd0};
    s_st = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    s_ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    s_ed = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s_st[i], 1'b0, (i < 6), {5'b0, s_in[i]});
      step();
      chk($sformatf("stall%0d.d2_valid", i), {31'b0, o2v}, {31'b0, s_ev[i]});
      chk($sformatf("stall%0d.d2_data", i),  {29'b0, o2d}, {29'b0, s_ed[i]});
    end

    // Fill with valid 7s, then flush and stall on the same edge
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h07);
      step();
    end
    chk("full.d4_data", {24'b0, o4d}, 32'h07);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h07);
    step();
    chk("flushstall.d3_valid", {31'b0, o3v}, 32'h0);
    chk("flushstall.d3_data", {29'b0, o3d}, 32'h0);
    chk("flushstall.d4_data", {24'b0, o4d}, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step();
      chk($sformatf("drain%0d.d4_valid", i), {31'b0, o4v}, 32'h0);
    end

    // Reset mid-stream on a full DEPTH=4 pipeline
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
      step();
    end
    chk("prereset.d4_valid", {31'b0, o4v}, 32'h1);
    chk("prereset.d4_data", {24'b0, o4d}, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
    step();
    chk("midreset.d4_valid", {31'b0, o4v}, 32'h0);
    chk("midreset.d4_data", {24'b0, o4d}, 32'hA5);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
    step();
    chk("release1.d4_valid", {31'b0, o4v}, 32'h0);
    for (int i = 2; i <= 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step();
      chk($sformatf("release%0d.d4_valid", i), {31'b0, o4v}, {31'b0, (i == 4)});
    end
    chk("release4.d4_data", {24'b0, o4d}, 32'h3C);

    // Randomised traffic against the reference queues
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            1'($urandom),
            8'($urandom));
      step();
    end

`ifdef PIPE_CTRL_STATS_EN
    // Five stall cycles, one of them also flushing, then two more flushes
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, (i == 2), 1'b1, 8'h01);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h02);
      step();
    end
    chk("stats.stall_cnt", {16'b0, sc[2]}, 32'd4);
    chk("stats.flush_cnt", {16'b0, fc[2]}, 32'd3);

    // Saturation after 70000 stall cycles
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (70000) @(posedge clk);
    m_sc = sat16(m_sc + 70000);
    #1;
    chk("sat.stall_cnt", {16'b0, sc[0]}, 32'hFFFF);
    chk("sat.flush_cnt", {16'b0, fc[0]}, 32'd3);
    step();
    chk("sat_hold.stall_cnt", {16'b0, sc[3]}, 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
